// File: rtl/seg_scan6.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan6
// Purpose  : 6-digit common-anode 7-segment scanner for HH:MM:SS packed BCD,
//            with per-field blink and a blank cycle at the start of each slot.
//            Optional macro SEG_LEADING_ZERO_BLANK_EN blanks a leading-zero
//            hour tens digit.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan6 #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] hour_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
    input  logic [2:0] blink_mask,
    output logic [7:0] seg,
    output logic [5:0] sel
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2((BLINK_DIV > 2) ? BLINK_DIV : 2);
    localparam logic [PW-1:0] c_scan_last  = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] c_blink_last = BW'(BLINK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [7:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [7:0]    seg_q, seg_d;
    logic [5:0]    sel_q, sel_d;

    logic [3:0]    nibble;
    logic          field_blink;
    logic          lz_blank;
    logic          frame_start;

    function automatic logic [6:0] decode7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        presc_d     = presc_q + PW'(1);
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        nibble      = 4'd0;
        field_blink = 1'b0;
        lz_blank    = 1'b0;
        sel_d       = 6'h3F;
        seg_d       = 8'hFF;

        if (presc_q == c_scan_last) begin
            presc_d = '0;
            idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        if (blink_cnt_q == c_blink_last) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        // Capture the whole time once per frame so a frame never mixes two times
        frame_start = (presc_q == '0) && (idx_q == 3'd0);
        if (frame_start) begin
            hour_d = hour_bcd;
            min_d  = min_bcd;
            sec_d  = sec_bcd;
        end

        case (idx_q)
            3'd0: begin nibble = sec_q[3:0];  field_blink = blink_mask[0]; end
            3'd1: begin nibble = sec_q[7:4];  field_blink = blink_mask[0]; end
            3'd2: begin nibble = min_q[3:0];  field_blink = blink_mask[1]; end
            3'd3: begin nibble = min_q[7:4];  field_blink = blink_mask[1]; end
            3'd4: begin nibble = hour_q[3:0]; field_blink = blink_mask[2]; end
            3'd5: begin nibble = hour_q[7:4]; field_blink = blink_mask[2]; end
            default: begin nibble = 4'd0;     field_blink = 1'b0;          end
        endcase

`ifdef SEG_LEADING_ZERO_BLANK_EN
        lz_blank = (idx_q == 3'd5) && (hour_q[7:4] == 4'd0);
`else
        lz_blank = 1'b0;
`endif

        if (presc_q != '0) begin
            sel_d = ~(6'b000001 << idx_q);
            if (!(phase_q && field_blink) && !lz_blank)
                seg_d = {~((idx_q == 3'd2) || (idx_q == 3'd4)), decode7(nibble)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q     <= '0;
            idx_q       <= 3'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            hour_q      <= 8'h00;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
            sel_q       <= 6'h3F;
            seg_q       <= 8'hFF;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    assign seg = seg_q;
    assign sel = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan6.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan6
// Purpose  : Randomized self-checking bench for seg_scan6 against a
//            time-indexed reference model of the scan/blink/snapshot rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan6;

    localparam int SD = 4;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] hour_bcd = 8'h00, min_bcd = 8'h00, sec_bcd = 8'h00;
    logic [2:0] blink_mask = 3'b000;
    logic [7:0] seg;
    logic [5:0] sel;

    int         n_checks = 0;
    int         n_errors = 0;
    int         t = 0;
    logic [7:0] snap_h = 8'h00, snap_m = 8'h00, snap_s = 8'h00;

    seg_scan6 #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hour_bcd   (hour_bcd),
        .min_bcd    (min_bcd),
        .sec_bcd    (sec_bcd),
        .blink_mask (blink_mask),
        .seg        (seg),
        .sel        (sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d: got %02h expected %02h", tag, t, obs, exp);
        end
    endtask

    // Active-low glyphs, dp off, digits 0-9 then dash for anything else
    function automatic logic [7:0] glyph(input logic [3:0] n);
        logic [7:0] tbl [0:9];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return (n <= 4'd9) ? tbl[n] : 8'hBF;
    endfunction

    // One clock with reset released; model state is a pure function of t
    task automatic step();
        int         slot_pos, digit, phase, field;
        logic [7:0] time_digits [0:5];
        logic [7:0] exp_seg;
        logic [5:0] exp_sel;
        @(posedge clk);
        slot_pos = t % SD;
        digit    = (t / SD) % 6;
        phase    = (t / BD) % 2;
        field    = digit / 2;
        if (slot_pos == 0 && digit == 0) begin
            snap_h = hour_bcd; snap_m = min_bcd; snap_s = sec_bcd;
        end
        time_digits = '{{4'h0, snap_s[3:0]}, {4'h0, snap_s[7:4]},
                        {4'h0, snap_m[3:0]}, {4'h0, snap_m[7:4]},
                        {4'h0, snap_h[3:0]}, {4'h0, snap_h[7:4]}};
        if (slot_pos == 0) begin
            exp_sel = 6'h3F;
            exp_seg = 8'hFF;
        end else begin
            exp_sel = 6'h3F ^ (6'd1 << digit);
            exp_seg = glyph(time_digits[digit][3:0]);
            if (digit == 2 || digit == 4) exp_seg[7] = 1'b0;
            if (phase == 1 && blink_mask[field]) exp_seg = 8'hFF;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (digit == 5 && snap_h[7:4] == 4'd0) exp_seg = 8'hFF;
`endif
        end
        #1;
        check("sel", {2'b00, sel}, {2'b00, exp_sel});
        check("seg", seg, exp_seg);
        t++;
    endtask

    task automatic reset_step();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_sel", {2'b00, sel}, 8'h3F);
        check("rst_seg", seg, 8'hFF);
        t = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        hour_bcd = 8'h23; min_bcd = 8'h59; sec_bcd = 8'h58; blink_mask = 3'b000;
        for (int i = 0; i < 3; i++) reset_step();
        rst_n = 1'b1;
        run(2 * 6 * SD);

        // Change seconds mid-frame; the current frame keeps the old snapshot
        while (((t / SD) % 6) != 2) step();
        sec_bcd = 8'h59;
        run(6 * SD + 8);

        min_bcd = 8'h5A;
        run(6 * SD);

        blink_mask = 3'b100;
        run(3 * 6 * SD);

        blink_mask = 3'b000; hour_bcd = 8'h07;
        run(2 * 6 * SD);
        blink_mask = 3'b100;
        run(2 * 6 * SD);

        // Reset mid-frame, then restart from the reset state
        while ((t % (6 * SD)) != 10) step();
        reset_step();
        reset_step();
        rst_n = 1'b1;
        run(2 * 6 * SD);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                hour_bcd   = 8'($urandom);
                min_bcd    = 8'($urandom);
                sec_bcd    = 8'($urandom);
                if ($urandom_range(0, 3) == 0) hour_bcd[7:4] = 4'd0;
                blink_mask = 3'($urandom);
            end
            if (i == 250) begin
                reset_step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
